// File: rtl/approx_mul_sweep_ctrl.sv
// Error-characterisation sequencer for the 4x4 approximate multiplier.
// Walks all 256 operand pairs, compares each result with the exact product and accumulates statistics.
`timescale 1ns/1ps
module approx_mul_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_result,
    output logic        busy,
    output logic        done,
    output logic        results_valid,
    output logic [15:0] sum_abs_err,
    output logic [8:0]  err_count,
    output logic [7:0]  max_abs_err,
    output logic [3:0]  max_err_a,
    output logic [3:0]  max_err_b
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] sum_q, sum_d;
    logic [8:0]  err_count_q, err_count_d;
    logic [7:0]  max_err_q, max_err_d;
    logic [3:0]  max_a_q, max_a_d;
    logic [3:0]  max_b_q, max_b_d;
    logic        valid_q, valid_d;

    logic [7:0]  exact;
    logic [7:0]  err;

    // The reference product comes only from the operand index, never from the multiplier under test.
    assign exact = {4'b0000, idx_q[7:4]} * {4'b0000, idx_q[3:0]};
    assign err   = (mul_result >= exact) ? (mul_result - exact) : (exact - mul_result);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        err_count_d = err_count_q;
        max_err_d   = max_err_q;
        max_a_d     = max_a_q;
        max_b_d     = max_b_q;
        valid_d     = valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SETTLE;
                    idx_d       = 8'd0;
                    cnt_d       = 4'd0;
                    sum_d       = 16'd0;
                    err_count_d = 9'd0;
                    max_err_d   = 8'd0;
                    max_a_d     = 4'd0;
                    max_b_d     = 4'd0;
                    valid_d     = 1'b0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else begin
                    sum_d       = sum_q + {8'd0, err};
                    err_count_d = err_count_q + {8'd0, (err != 8'd0)};
                    // Strictly greater so ties keep the earliest pair.
                    if (err > max_err_q) begin
                        max_err_d = err;
                        max_a_d   = idx_q[7:4];
                        max_b_d   = idx_q[3:0];
                    end
                    if (idx_q == 8'hFF) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end else begin
                        state_d = SETTLE;
                        idx_d   = idx_q + 8'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 8'd0;
            cnt_q       <= 4'd0;
            sum_q       <= 16'd0;
            err_count_q <= 9'd0;
            max_err_q   <= 8'd0;
            max_a_q     <= 4'd0;
            max_b_q     <= 4'd0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            err_count_q <= err_count_d;
            max_err_q   <= max_err_d;
            max_a_q     <= max_a_d;
            max_b_q     <= max_b_d;
            valid_q     <= valid_d;
        end
    end

    assign mul_a         = idx_q[7:4];
    assign mul_b         = idx_q[3:0];
    assign busy          = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done          = (state_q == DONE);
    assign results_valid = valid_q;
    assign sum_abs_err   = sum_q;
    assign err_count     = err_count_q;
    assign max_abs_err   = max_err_q;
    assign max_err_a     = max_a_q;
    assign max_err_b     = max_b_q;

endmodule

// File: tb/tb_approx_mul_sweep_ctrl.sv
// Scoreboard bench for approx_mul_sweep_ctrl: two instances (SETTLE_CYCLES 1 and 3) driven by a behavioural
// multiplier model; expected sweep statistics are queued at start and checked by a monitor on each done pulse.
`timescale 1ns/1ps
module tb_approx_mul_sweep_ctrl;

    localparam int MODE_EXACT = 0;
    localparam int MODE_LSB0  = 1;
    localparam int MODE_ZERO  = 2;

    typedef struct {
        logic [15:0] sum;
        logic [8:0]  cnt;
        logic [7:0]  maxe;
        logic [3:0]  ma;
        logic [3:0]  mb;
        int          doneCycle;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst1_n, start1, abort1, busy1, done1, valid1;
    logic [3:0]  a1, b1, ma1, mb1;
    logic [7:0]  res1, max1;
    logic [15:0] sum1;
    logic [8:0]  cnt1;

    logic        rst3_n, start3, abort3, busy3, done3, valid3;
    logic [3:0]  a3, b3, ma3, mb3;
    logic [7:0]  res3, max3;
    logic [15:0] sum3;
    logic [8:0]  cnt3;

    int mode1 = MODE_EXACT;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    int checkCount = 0;
    int passCount  = 0;

    function automatic logic [7:0] mulModel(input int mode, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = {4'b0000, a} * {4'b0000, b};
        case (mode)
            MODE_LSB0: mulModel = {p[7:1], 1'b0};
            MODE_ZERO: mulModel = 8'd0;
            default:   mulModel = p;
        endcase
    endfunction

    assign res1 = mulModel(mode1, a1, b1);
    assign res3 = mulModel(MODE_EXACT, a3, b3);

    approx_mul_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .start(start1), .abort(abort1),
        .mul_a(a1), .mul_b(b1), .mul_result(res1),
        .busy(busy1), .done(done1), .results_valid(valid1),
        .sum_abs_err(sum1), .err_count(cnt1), .max_abs_err(max1),
        .max_err_a(ma1), .max_err_b(mb1)
    );

    approx_mul_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .start(start3), .abort(abort3),
        .mul_a(a3), .mul_b(b3), .mul_result(res3),
        .busy(busy3), .done(done3), .results_valid(valid3),
        .sum_abs_err(sum3), .err_count(cnt3), .max_abs_err(max3),
        .max_err_a(ma3), .max_err_b(mb3)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic checkSweep(input string tag, input exp_t e, input logic [15:0] sum, input logic [8:0] cnt,
                              input logic [7:0] maxe, input logic [3:0] ma, input logic [3:0] mb,
                              input logic valid);
        checkOutput({tag, " sum_abs_err"}, sum, e.sum);
        checkOutput({tag, " err_count"}, cnt, e.cnt);
        checkOutput({tag, " max_abs_err"}, maxe, e.maxe);
        checkOutput({tag, " max_err_a"}, ma, e.ma);
        checkOutput({tag, " max_err_b"}, mb, e.mb);
        checkOutput({tag, " results_valid"}, valid, 1);
        checkOutput({tag, " done cycle"}, cyc, e.doneCycle);
    endtask

    // Monitor: every done pulse pops the oldest expected sweep; a done with nothing queued is itself an error.
    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) checkOutput("dut1 unexpected done", 1, 0);
            else begin
                e1 = q1.pop_front();
                checkSweep("dut1", e1, sum1, cnt1, max1, ma1, mb1, valid1);
            end
        end
        if (done3) begin
            if (q3.size() == 0) checkOutput("dut3 unexpected done", 1, 0);
            else begin
                e3 = q3.pop_front();
                checkSweep("dut3", e3, sum3, cnt3, max3, ma3, mb3, valid3);
            end
        end
    end

    // Called at a negedge; start is sampled at the next posedge, done follows 256*(S+1) edges later.
    task automatic applyStimulus(input bit onDut3, input bit pushExp, input bit withAbort,
                                 input logic [15:0] sum, input logic [8:0] cnt, input logic [7:0] maxe,
                                 input logic [3:0] ma, input logic [3:0] mb);
        exp_t e;
        int settle;
        settle = onDut3 ? 3 : 1;
        e.sum = sum; e.cnt = cnt; e.maxe = maxe; e.ma = ma; e.mb = mb;
        e.doneCycle = cyc + 1 + 256 * (settle + 1);
        if (pushExp) begin
            if (onDut3) q3.push_back(e);
            else        q1.push_back(e);
        end
        if (onDut3) begin start3 = 1'b1; abort3 = withAbort; end
        else        begin start1 = 1'b1; abort1 = withAbort; end
        @(negedge clk);
        start1 = 1'b0; abort1 = 1'b0;
        start3 = 1'b0; abort3 = 1'b0;
    endtask

    task automatic waitDrain(input bit onDut3, input int bound);
        int left;
        left = onDut3 ? q3.size() : q1.size();
        for (int i = 0; i < bound && left != 0; i++) begin
            @(negedge clk);
            left = onDut3 ? q3.size() : q1.size();
        end
        checkOutput(onDut3 ? "dut3 sweep completion" : "dut1 sweep completion", left, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst1_n = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        rst3_n = 1'b0; start3 = 1'b0; abort3 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", busy1, 0);
        checkOutput("reset done", done1, 0);
        checkOutput("reset results_valid", valid1, 0);
        checkOutput("reset mul_a", a1, 0);
        checkOutput("reset sum", sum1, 0);
        rst1_n = 1'b1; rst3_n = 1'b1;
        @(negedge clk);

        // Exact multiplier, with an ignored start re-pulse at cycle 100.
        mode1 = MODE_EXACT;
        applyStimulus(0, 1, 0, 16'd0, 9'd0, 8'd0, 4'd0, 4'd0);
        checkOutput("dut1 busy cycle 1", busy1, 1);
        repeat (98) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        waitDrain(0, 1000);
        repeat (2) @(negedge clk);
        checkOutput("dut1 results_valid held", valid1, 1);
        checkOutput("dut1 done single pulse", done1, 0);

        mode1 = MODE_LSB0;
        applyStimulus(0, 1, 0, 16'd64, 9'd64, 8'd1, 4'd1, 4'd1);
        waitDrain(0, 1000);

        mode1 = MODE_ZERO;
        applyStimulus(0, 1, 0, 16'd14400, 9'd225, 8'd225, 4'd15, 4'd15);
        waitDrain(0, 1000);
        @(negedge clk);

        // Abort at cycle 200: no done may follow (the monitor flags one).
        mode1 = MODE_EXACT;
        applyStimulus(0, 0, 0, 16'd0, 9'd0, 8'd0, 4'd0, 4'd0);
        checkOutput("dut1 valid cleared by start", valid1, 0);
        repeat (198) @(negedge clk);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        checkOutput("abort busy", busy1, 0);
        checkOutput("abort results_valid", valid1, 0);
        repeat (600) @(negedge clk);
        checkOutput("abort stays idle", busy1, 0);

        // Asynchronous reset at cycle 300 of an erroneous sweep.
        mode1 = MODE_LSB0;
        applyStimulus(0, 0, 0, 16'd0, 9'd0, 8'd0, 4'd0, 4'd0);
        repeat (298) @(negedge clk);
        checkOutput("pre-reset sum nonzero", (sum1 != 16'd0), 1);
        #2 rst1_n = 1'b0;
        #1;
        checkOutput("async reset busy", busy1, 0);
        checkOutput("async reset mul_a", a1, 0);
        checkOutput("async reset mul_b", b1, 0);
        checkOutput("async reset sum", sum1, 0);
        checkOutput("async reset err_count", cnt1, 0);
        checkOutput("async reset max", max1, 0);
        @(negedge clk);
        rst1_n = 1'b1;
        @(negedge clk);
        applyStimulus(0, 1, 0, 16'd64, 9'd64, 8'd1, 4'd1, 4'd1);
        waitDrain(0, 1000);

        // SETTLE_CYCLES=3, start and abort together in IDLE: start wins.
        applyStimulus(1, 1, 1, 16'd0, 9'd0, 8'd0, 4'd0, 4'd0);
        checkOutput("s3 busy cycle 1", busy3, 1);
        checkOutput("s3 mul_b cycle 1", b3, 0);
        repeat (3) @(negedge clk);
        checkOutput("s3 mul_b cycle 4", b3, 0);
        @(negedge clk);
        checkOutput("s3 mul_b cycle 5", b3, 1);
        checkOutput("s3 mul_a cycle 5", a3, 0);
        repeat (64) @(negedge clk);
        checkOutput("s3 mul_a cycle 69", a3, 1);
        checkOutput("s3 mul_b cycle 69", b3, 1);
        repeat (955) @(negedge clk);
        checkOutput("s3 busy cycle 1024", busy3, 1);
        repeat (2) @(negedge clk);
        checkOutput("s3 busy cycle 1026", busy3, 0);
        waitDrain(1, 20);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/approx_mul_sweep_ctrl.md
Name: approx_mul_sweep_ctrl

Overview:
Hardware error-characterisation sequencer for the 4x4 approximate multiplier. On a start request it walks all 256 operand pairs through one external approximate_multiplier instance and compares each result against an internally computed exact product. It accumulates the total absolute error, the mismatch count and the worst-case error with its operands. It sits beside the multiplier in the characterisation/BIST wrapper, so error statistics are produced on-chip instead of by simulation.

Parameters:
SETTLE_CYCLES, 1, cycles operands are held on mul_a/mul_b before mul_result is sampled (legal 1..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  sweep request, sampled only in IDLE
abort  input  1  synchronous cancel, sampled in SETTLE/SAMPLE
mul_a  output  4  operand A to multiplier, registered
mul_b  output  4  operand B to multiplier, registered
mul_result  input  8  approximate product from multiplier
busy  output  1  high in SETTLE/SAMPLE
done  output  1  one-cycle pulse when sweep completes
results_valid  output  1  statistics valid, held until next start/abort
sum_abs_err  output  16  sum of |approx-exact| over all 256 pairs
err_count  output  9  number of pairs with approx != exact (0..256)
max_abs_err  output  8  largest |approx-exact| seen
max_err_a  output  4  A operand of first pair reaching max_abs_err
max_err_b  output  4  B operand of first pair reaching max_abs_err

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; idx=0; settle counter=0. Reset mid-sweep discards everything and gives no done.
- idx[7:0] is the pair index. mul_a=idx[7:4], mul_b=idx[3:0]. exact=mul_a*mul_b (8-bit, unsigned). Pair order 0x00..0xFF.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: when start=1 at an edge, go to SETTLE. idx=0, counter=0. Clear sum_abs_err/err_count/max_*, results_valid=0.
- SETTLE: hold operands. Count SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (one cycle): err=|mul_result-exact| (8-bit unsigned, computed without wrap).
  - sum_abs_err += err.
  - err_count += (err!=0).
  - If err > max_abs_err (strictly greater), update max_abs_err/max_err_a/max_err_b. Ties keep the earliest pair. A sweep with zero error reports max_abs_err=0, max_err_a=0, max_err_b=0.
  - If idx==255, go to DONE. Otherwise idx+1 and go to SETTLE (operands change at the same edge).
- DONE (one cycle): done=1, results_valid=1. Next state is IDLE. results_valid stays 1 until the next accepted start.
- Latency: start sampled at edge 0. Pair k occupies cycles k*(S+1)+1 .. (k+1)*(S+1), where S=SETTLE_CYCLES. done is high in cycle 256*(S+1)+1 (cycle 513 for S=1).
- Sum width: max 256*255=65280, so no overflow in 16 bits.
- start while busy or in DONE: ignored, no queuing.
- abort=1 in SETTLE/SAMPLE: next state IDLE, results_valid=0, no done. The accumulators keep partial values but are invalid. abort takes priority over a SAMPLE transition at the same edge. abort in IDLE/DONE is ignored.
- start and abort both high in IDLE: start wins.
- Operands stay at their last value in IDLE/DONE. The exact product is from the internal multiply only, never from mul_result.

Test Plan:
- Exact model (mul_result=a*b), S=1, pulse start -> done in cycle 513; sum=0, err_count=0, max_abs_err=0, max_err_a/b=0, results_valid=1.
- Model forcing product LSB to 0 -> sum=64, err_count=64, max_abs_err=1, max_err_a=1, max_err_b=1.
- Model returning 0 -> sum=14400, err_count=225, max_abs_err=225, max_err_a=15, max_err_b=15.
- S=3 with exact model -> done in cycle 1025; busy high cycles 1..1024; operands advance every 4 cycles.
- Start re-pulsed at cycle 100 -> ignored, done still in cycle 513. Then abort at cycle 200 of a new sweep -> IDLE next cycle, no done, results_valid=0.
- rst_n low at cycle 300 mid-sweep -> all outputs 0 immediately (async). A new start after release runs a full clean sweep.
